// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux serializer: FSM state encodings and the
// helper that sizes the bit counter.
// No ports (package).
// -----------------------------------------------------------------------------
package demux_pkg;

    // Code 2'd3 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ceil(log2(width)) + 1 bits: always able to hold the value width.
    function automatic int bitcnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/demux_serializer_if.sv
// -----------------------------------------------------------------------------
// demux_serializer_if
// Handshake and serial-output bundle between an upstream word source and the
// demux serializer.
//   in_valid/in_data/in_chan/flush : upstream -> serializer
//   in_ready                       : serializer -> upstream
//   a/en/s                         : serial bit, demux enable, demux select
//   busy/done                      : word-in-flight status, end-of-word pulse
// Modports: master = upstream side, slave = serializer side.
// -----------------------------------------------------------------------------
interface demux_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_chan;
    logic             flush;
    logic             in_ready;
    logic             a;
    logic             en;
    logic             s;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, in_chan, flush,
        input  in_ready, a, en, s, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_chan, flush,
        output in_ready, a, en, s, busy, done
    );
endinterface

// File: rtl/demux12.sv
// -----------------------------------------------------------------------------
// demux12
// 1:2 demultiplexer fed by the serializer.
//   a  : data bit
//   en : enable; both outputs are 0 when low
//   s  : select; 0 -> y[0], 1 -> y[1]
//   y  : routed outputs
// -----------------------------------------------------------------------------
module demux12 (
    input  logic       a,
    input  logic       en,
    input  logic       s,
    output logic [1:0] y
);

    assign y[0] = en & ~s & a;
    assign y[1] = en &  s & a;

endmodule

// File: rtl/ser_bitcnt.sv
// -----------------------------------------------------------------------------
// ser_bitcnt
// Counts SHIFT cycles of the serializer and flags the last bit of a word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : load zero (word accepted)
//   inc   : count one shifted bit
//   tc    : high while the counter holds WIDTH-1 (last bit on the line)
// -----------------------------------------------------------------------------
module ser_bitcnt
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = bitcnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/demux_serializer.sv
// -----------------------------------------------------------------------------
// demux_serializer
// Accepts a WIDTH-bit word plus a channel bit, then shifts it out LSB first on
// 'a' for WIDTH cycles with en=1 and s=channel, then pulses done for one
// cycle. flush aborts a word in flight; reset aborts it asynchronously.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_serializer_if.slave (handshake, serial outputs, status)
// Every output comes straight from a flop; the flops are loaded from the
// next-state decode so outputs change on the same edge as the state.
// -----------------------------------------------------------------------------
module demux_serializer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_serializer_if.slave     bus
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               chan_q, chan_d;
    logic               in_ready_q, in_ready_d;
    logic               a_q, a_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               cnt_tc;

    ser_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        chan_d  = chan_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // in_ready_q gates acceptance so nothing is taken on the
                // first edge after reset; flush blocks acceptance.
                if (bus.in_valid && in_ready_q && !bus.flush) begin
                    state_d = ST_SHIFT;
                    shreg_d = bus.in_data;
                    chan_d  = bus.in_chan;
                    cnt_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = shreg_q >> 1;
                    cnt_inc = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flops are decoded from the state being entered.
        in_ready_d = (state_d == ST_IDLE);
        en_d       = (state_d == ST_SHIFT);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        a_d        = en_d & shreg_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            chan_q     <= 1'b0;
            in_ready_q <= 1'b0;
            a_q        <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            chan_q     <= chan_d;
            in_ready_q <= in_ready_d;
            a_q        <= a_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.a        = a_q;
    assign bus.en       = en_q;
    assign bus.s        = chan_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_demux_serializer.sv
// -----------------------------------------------------------------------------
// tb_demux_serializer
// Directed bench for demux_serializer (WIDTH=8) driving a demux12. A
// word-level model (accept cycle, word, channel, in_ready) predicts every
// output each cycle; directed checks pin literal bit streams and timings.
// -----------------------------------------------------------------------------
module tb_demux_serializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] y;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    demux_serializer_if #(.WIDTH(W)) bus ();

    demux_serializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    demux12 u_demux (
        .a  (bus.a),
        .en (bus.en),
        .s  (bus.s),
        .y  (y)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    // cyc counts rising edges; m_k is the edge at which the word in flight was
    // accepted. After edge m_k+j the line carries bit j (j<W), then done.
    int         cyc     = 0;
    int         m_k     = 0;
    bit         m_act   = 1'b0;
    logic [7:0] m_word  = '0;
    logic       m_s     = 1'b0;
    logic       m_ready = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act   <= 1'b0;
            m_ready <= 1'b0;
            m_s     <= 1'b0;
        end else if (m_act) begin
            if (bus.flush || ((cyc + 1 - m_k) == W + 1)) begin
                m_act   <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_ready && bus.in_valid && !bus.flush) begin
            m_act   <= 1'b1;
            m_k     <= cyc + 1;
            m_word  <= bus.in_data;
            m_s     <= bus.in_chan;
            m_ready <= 1'b0;
        end else begin
            m_ready <= 1'b1;
        end
        cyc <= cyc + 1;
    end

    int         p;
    logic       e_ready, e_a, e_en, e_s, e_busy, e_done;
    logic [1:0] e_y;

    always_comb begin
        p       = cyc - m_k;
        e_ready = m_ready;
        e_a     = 1'b0;
        e_en    = 1'b0;
        e_s     = m_s;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        if (!rst_n) begin
            e_ready = 1'b0;
            e_s     = 1'b0;
        end else if (m_act) begin
            e_ready = 1'b0;
            e_busy  = 1'b1;
            if (p < W) begin
                e_en = 1'b1;
                e_a  = m_word[p[2:0]];
            end else begin
                e_done = 1'b1;
            end
        end
        e_y = 2'b00;
        if (e_en && e_a) begin
            e_y = e_s ? 2'b10 : 2'b01;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_in_ready", 16'(bus.in_ready), 16'(e_ready));
            chk("cmp_a",        16'(bus.a),        16'(e_a));
            chk("cmp_en",       16'(bus.en),       16'(e_en));
            chk("cmp_s",        16'(bus.s),        16'(e_s));
            chk("cmp_busy",     16'(bus.busy),     16'(e_busy));
            chk("cmp_done",     16'(bus.done),     16'(e_done));
            chk("cmp_y",        16'(y),            16'(e_y));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_start(input logic [7:0] d, input logic c);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_chan  = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [7:0] cap;
        int         first_ff;
        int         dcount;
        int         rises;
        logic       en_prev;

        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_chan  = 1'b0;
        bus.flush    = 1'b0;
        #2;
        // Reset held 3 cycles with in_valid high.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        cmp_en       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(bus.in_ready), 16'h0);
        chk("rst_en",       16'(bus.en),       16'h0);
        chk("rst_busy",     16'(bus.busy),     16'h0);
        chk("rst_done",     16'(bus.done),     16'h0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 16'(bus.in_ready), 16'h1);
        chk("rel_busy",     16'(bus.busy),     16'h0);

        // 8'hA5 on channel 0.
        send_start(8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("a5_y0", 16'(y[0]), 16'(exp_a5[i]));
            chk("a5_y1", 16'(y[1]), 16'h0);
        end
        @(negedge clk);
        chk("a5_done", 16'(bus.done), 16'h1);
        @(posedge clk);
        #1;

        // 8'h3C on channel 1, then 8'hFF on channel 0 held valid.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        bus.in_chan  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_data  = 8'hFF;
        bus.in_chan  = 1'b0;
        cap      = '0;
        first_ff = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n < 8) cap = {y[1], cap[7:1]};
            if (first_ff < 0 && bus.en && !bus.s) first_ff = n;
            if (n == 10) bus.in_valid = 1'b0;
        end
        chk("3c_word",     16'(cap),      16'h003C);
        chk("ff_accept_k", 16'(first_ff), 16'd10);
        repeat (9) @(posedge clk);
        #1;
        chk("ff_drained_ready", 16'(bus.in_ready), 16'h1);

        // 8'hF0 flushed in its 4th SHIFT cycle.
        send_start(8'hF0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("f0_pre_en", 16'(bus.en), 16'h1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_en",       16'(bus.en),       16'h0);
        chk("flush_busy",     16'(bus.busy),     16'h0);
        chk("flush_in_ready", 16'(bus.in_ready), 16'h1);
        dcount = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("flush_no_done", 16'(dcount), 16'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset in mid-SHIFT, then 8'h01.
        send_start(8'hC3, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_en", 16'(bus.en), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async_en",   16'(bus.en),   16'h0);
        chk("async_busy", 16'(bus.busy), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_in_ready", 16'(bus.in_ready), 16'h1);
        send_start(8'h01, 1'b0);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cap = {y[0], cap[7:1]};
        end
        chk("w01_word", 16'(cap), 16'h0001);
        @(negedge clk);
        chk("w01_done", 16'(bus.done), 16'h1);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        @(negedge clk);
        chk("b2b_ready_first", 16'(bus.in_ready), 16'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h96;
        bus.in_chan  = 1'b1;
        dcount  = 0;
        rises   = 0;
        en_prev = bus.en;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("b2b_ready", 16'(bus.in_ready), 16'((n % 10) == 9));
            if (bus.done) dcount++;
            if (bus.en && !en_prev) rises++;
            en_prev = bus.en;
        end
        chk("b2b_done_cnt", 16'(dcount), 16'd2);
        chk("b2b_words",    16'(rises),  16'd2);
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("end_in_ready", 16'(bus.in_ready), 16'h1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/demux_serializer.md
DEMUX_SERIALIZER -- requirements
Module: demux_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of bits per word (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream asserts when in_data and in_chan are valid.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_chan  input  1  target channel for the word: 0 routes to y[0], 1 routes to y[1].
REQ-007 flush  input  1  synchronous abort of the word currently being sent.
REQ-008 in_ready  output  1  high when a word can be accepted.
REQ-009 a  output  1  serial data bit to the 1:2 demux.
REQ-010 en  output  1  demux enable; high only while a bit is being driven.
REQ-011 s  output  1  demux select; equals the latched in_chan.
REQ-012 busy  output  1  high while a word is in flight.
REQ-013 done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-014 The block SHALL register every output; no output is combinational from an input.
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, in_ready=1, en=0, busy=0 and a=0.
REQ-017 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
- On acceptance, in_data is loaded into the shift register, in_chan is latched, the bit count is cleared, and the next state is SHIFT.
REQ-018 On the accepting edge, in_ready SHALL fall, and en, busy and s SHALL take their SHIFT values.
- First bit (in_data[0], LSB first) appears on a in the cycle immediately after acceptance.
REQ-019 In SHIFT, en=1, busy=1, s=latched channel and a=current shift-register LSB; the register shifts right by one bit per cycle.
REQ-020 SHIFT SHALL last exactly WIDTH cycles, using a counter of ceil(log2(WIDTH))+1 bits, then move to DONE.
REQ-021 In DONE, the block SHALL drive en=0, a=0, busy=1, in_ready=0 and done=1 for one cycle, then return to IDLE with in_ready=1.
REQ-022 Timing: if a word is accepted at edge k, its bits appear in cycles k+1..k+WIDTH, done appears in cycle k+WIDTH+1, and the next acceptance is possible at edge k+WIDTH+2.
REQ-023 While in_ready=0, in_valid, in_data and in_chan SHALL be ignored, and a changing in_data SHALL NOT affect the word in flight.
REQ-024 flush=1 in SHIFT or DONE SHALL force IDLE on the next edge.
- Sets en=0 and busy=0; done is not pulsed; in_ready=1 the following cycle.
- flush in IDLE has no effect, and flush takes priority over acceptance on the same edge.
REQ-025 s SHALL remain stable for the whole SHIFT period; a channel change only takes effect on the next acceptance.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and in_ready, a, en, s, busy, done, the shift register and the counter SHALL all be 0.
REQ-027 in_ready SHALL rise on the first rising edge after rst_n deasserts; no word is accepted while rst_n=0.
REQ-028 Reset asserted mid-word SHALL abort it immediately and asynchronously, with en falling without waiting for a clock edge.

Structure
REQ-029 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in the shared package demux_pkg.
- Unused code 2'd3 SHALL recover to IDLE.
REQ-030 The bit counter SHALL be the sub-module ser_bitcnt, with ports clk, rst_n, clr, inc and terminal-count output tc.

Verification (WIDTH=8; the bench connects a, en and s to a demux12 instance)
REQ-031 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> all outputs 0, no acceptance, and in_ready=1 one edge after release.
REQ-032 Word 8'hA5 on chan 0 -> y[0] carries 1,0,1,0,0,1,0,1 over cycles k+1..k+8, y[1] stays 0, and done pulses at k+9.
REQ-033 Word 8'h3C on chan 1, followed by a second word 8'hFF on chan 0 held valid during SHIFT -> 8'hFF is accepted only at k+10 and y[1] receives exactly 8'h3C.
REQ-034 flush asserted in the 4th SHIFT cycle of 8'hF0 -> en=0 on the next edge, no done, and in_ready=1 one cycle later.
REQ-035 rst_n pulsed low mid-SHIFT -> en and busy fall asynchronously, and a new word 8'h01 afterwards serializes correctly.
REQ-036 Back-to-back words with in_valid held high -> in_ready pattern 1,0x9,1 and throughput of exactly one word per 10 cycles.
